// File: rtl/ord_tx_if.sv
// Bundle of the order-input, outbound-beat and statistics signals of ord_tx.
// master is the surrounding logic (upstream, MAC and host); slave is ord_tx itself.
interface ord_tx_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 128,
  parameter int OUT_WIDTH  = 64
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  ord_valid;
  logic [DATA_WIDTH-1:0] ord_data;
  logic                  ord_ready;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [OUT_WIDTH-1:0]  tx_data;
  logic                  tx_sop;
  logic                  tx_eop;
  logic                  clr_stats;
  logic [15:0]           drop_cnt;
  logic                  overflow;
  logic [LW-1:0]         fifo_level;

  modport master (
    output ord_valid, ord_data, tx_ready, clr_stats,
    input  ord_ready, tx_valid, tx_data, tx_sop, tx_eop, drop_cnt, overflow, fifo_level
  );

  modport slave (
    input  ord_valid, ord_data, tx_ready, clr_stats,
    output ord_ready, tx_valid, tx_data, tx_sop, tx_eop, drop_cnt, overflow, fifo_level
  );
endinterface

// File: rtl/ord_tx.sv
// Order transmitter: buffers 128-bit order records in a small FIFO and frames each
// one as a 3-beat packet (header with sequence number, two payload beats).
module ord_tx #(
  parameter int          DEPTH      = 4,
  parameter int          DATA_WIDTH = 128,
  parameter int          OUT_WIDTH  = 64,
  parameter logic [15:0] HDR_TAG    = 16'hA55A,
  parameter logic [31:0] SEQ_INIT   = 32'h0000_0000
) (
  input logic     clk,
  input logic     reset_n,
  ord_tx_if.slave ord_io
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, HDR, PL0, PL1} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wrPtr_q;
  logic [AW-1:0]         rdPtr_q;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;
  logic [31:0]           seq_q;
  state_t                state_q;
  logic                  txValid_q;
  logic                  txSop_q;
  logic                  txEop_q;
  logic [OUT_WIDTH-1:0]  txData_q;
  logic [15:0]           dropCnt_q;
  logic                  overflow_q;

  logic                  full;
  logic                  pushEn;
  logic                  dropEv;
  logic                  popEn;
  logic                  accept;
  logic [DATA_WIDTH-1:0] head;
  logic [31:0]           seqNext;

  function automatic logic [OUT_WIDTH-1:0] hdrBeat(input logic [31:0] s);
    return {HDR_TAG, 16'h0000, s};
  endfunction

  // Fullness uses the registered level only, so a same-cycle pop never rescues a push.
  assign full    = (level_q == LW'(DEPTH));
  assign pushEn  = ord_io.ord_valid && !full;
  assign dropEv  = ord_io.ord_valid && full;
  assign accept  = txValid_q && ord_io.tx_ready;
  assign popEn   = accept && txEop_q;
  assign head    = mem[rdPtr_q];
  assign seqNext = seq_q + 32'd1;

  always_comb begin
    level_d = level_q;
    if (pushEn && !popEn) begin
      level_d = level_q + LW'(1);
    end else if (!pushEn && popEn) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && pushEn) begin
      mem[wrPtr_q] <= ord_io.ord_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (pushEn) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (popEn) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // A clear in the same cycle as a drop wipes the old count first, then counts the drop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dropCnt_q  <= '0;
      overflow_q <= 1'b0;
    end else if (ord_io.clr_stats) begin
      dropCnt_q  <= dropEv ? 16'd1 : 16'd0;
      overflow_q <= dropEv;
    end else if (dropEv) begin
      if (dropCnt_q != 16'hFFFF) begin
        dropCnt_q <= dropCnt_q + 16'd1;
      end
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      seq_q     <= SEQ_INIT;
      txValid_q <= 1'b0;
      txSop_q   <= 1'b0;
      txEop_q   <= 1'b0;
      txData_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            state_q   <= HDR;
            txValid_q <= 1'b1;
            txSop_q   <= 1'b1;
            txData_q  <= hdrBeat(seq_q);
          end
        end
        HDR: begin
          if (ord_io.tx_ready) begin
            state_q  <= PL0;
            txSop_q  <= 1'b0;
            txData_q <= head[DATA_WIDTH-1:OUT_WIDTH];
          end
        end
        PL0: begin
          if (ord_io.tx_ready) begin
            state_q  <= PL1;
            txEop_q  <= 1'b1;
            txData_q <= head[OUT_WIDTH-1:0];
          end
        end
        PL1: begin
          if (ord_io.tx_ready) begin
            seq_q   <= seqNext;
            txEop_q <= 1'b0;
            // Another record already queued: its header follows without a bubble.
            if (level_q > LW'(1)) begin
              state_q  <= HDR;
              txSop_q  <= 1'b1;
              txData_q <= hdrBeat(seqNext);
            end else begin
              state_q   <= IDLE;
              txValid_q <= 1'b0;
              txData_q  <= '0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          txValid_q <= 1'b0;
          txSop_q   <= 1'b0;
          txEop_q   <= 1'b0;
          txData_q  <= '0;
        end
      endcase
    end
  end

  assign ord_io.ord_ready  = !full;
  assign ord_io.tx_valid   = txValid_q;
  assign ord_io.tx_data    = txData_q;
  assign ord_io.tx_sop     = txSop_q;
  assign ord_io.tx_eop     = txEop_q;
  assign ord_io.drop_cnt   = dropCnt_q;
  assign ord_io.overflow   = overflow_q;
  assign ord_io.fifo_level = level_q;
endmodule
